// File: rtl/ifetch_queue_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, redirect and decode handshake.
// Carries fetch_misalign only when IFETCH_MISALIGN_CHECK_EN is defined.
interface ifetch_queue_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc_plus4;
`ifdef IFETCH_MISALIGN_CHECK_EN
    logic        fetch_misalign;
`endif

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_pc,
        output instr_valid, instr, instr_pc, instr_pc_plus4,
        input  instr_ready
`ifdef IFETCH_MISALIGN_CHECK_EN
        , output fetch_misalign
`endif
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_pc,
        input  instr_valid, instr, instr_pc, instr_pc_plus4,
        output instr_ready
`ifdef IFETCH_MISALIGN_CHECK_EN
        , input fetch_misalign
`endif
    );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: PC owner, in-order imem requests, prefetch FIFO, redirect flush.
// Optional misaligned-redirect HALT state enabled by IFETCH_MISALIGN_CHECK_EN.
module ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic           clk,
    input logic           reset,
    ifetch_queue_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    typedef logic [AW:0] cnt_t;
    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

    state_t          state_q, state_d;
    logic [31:0]     fetch_pc;
    cnt_t            count, outstanding, kill, occ, outstanding_nx;
    logic [AW-1:0]   head, tail, tag_wr, tag_rd;
    logic [31:0]     fifo_data [DEPTH];
    logic [31:0]     fifo_pc   [DEPTH];
    logic [31:0]     tag_pc    [DEPTH];
    logic            redir, redir_bad, req_valid, accept, rsp, rsp_kill, push, pop, head_valid;

    assign redir = bus.redirect_valid;
`ifdef IFETCH_MISALIGN_CHECK_EN
    logic misalign_q;
    assign redir_bad          = redir && (bus.redirect_pc[1:0] != 2'b00);
    assign bus.fetch_misalign = misalign_q;
`else
    logic unused_pc_lsb;
    assign redir_bad     = 1'b0;
    assign unused_pc_lsb = ^bus.redirect_pc[1:0];
`endif

    // Credit uses registered occupancy only, so a pop frees its slot one cycle later.
    assign occ            = count + outstanding;
    assign accept         = req_valid && bus.imem_req_ready;
    assign rsp            = bus.imem_rsp_valid && (outstanding != '0);
    assign rsp_kill       = rsp && (kill != '0);
    assign push           = rsp && !rsp_kill && !redir;
    assign head_valid     = (count != '0);
    assign pop            = head_valid && bus.instr_ready;
    assign outstanding_nx = outstanding + cnt_t'(accept) - cnt_t'(rsp);

    always_comb begin
        state_d   = state_q;
        req_valid = 1'b0;
        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     req_valid = (occ < cnt_t'(DEPTH)) && !redir;
            HALT:    state_d = HALT;
            default: state_d = BOOT;
        endcase
        if (redir) state_d = redir_bad ? HALT : RUN;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= BOOT;
            fetch_pc    <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            kill        <= '0;
            head        <= '0;
            tail        <= '0;
            tag_wr      <= '0;
            tag_rd      <= '0;
`ifdef IFETCH_MISALIGN_CHECK_EN
            misalign_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            outstanding <= outstanding_nx;
            if (accept) tag_wr <= tag_wr + 1'b1;
            if (rsp)    tag_rd <= tag_rd + 1'b1;
            if (redir) begin
                // Everything still in flight after this edge belongs to the old stream.
                fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
                kill     <= outstanding_nx;
                count    <= '0;
                head     <= '0;
                tail     <= '0;
`ifdef IFETCH_MISALIGN_CHECK_EN
                misalign_q <= redir_bad;
`endif
            end else begin
                if (accept)   fetch_pc <= fetch_pc + 32'd4;
                if (rsp_kill) kill     <= kill - 1'b1;
                count <= count + cnt_t'(push) - cnt_t'(pop);
                if (push) tail <= tail + 1'b1;
                if (pop)  head <= head + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) tag_pc[tag_wr] <= fetch_pc;
        if (push) begin
            fifo_data[tail] <= bus.imem_rsp_data;
            fifo_pc[tail]   <= tag_pc[tag_rd];
        end
    end

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = {fetch_pc[31:2], 2'b00};
    assign bus.instr_valid    = head_valid;
    assign bus.instr          = head_valid ? fifo_data[head] : 32'h0;
    assign bus.instr_pc       = head_valid ? fifo_pc[head] : 32'h0;
    assign bus.instr_pc_plus4 = head_valid ? fifo_pc[head] + 32'd4 : 32'h0;
endmodule

// File: tb/tb_ifetch_queue.sv
// Scoreboard bench for ifetch_queue: memory model with random latency/ready, decoupled monitor,
// directed test-plan scenarios followed by a randomized redirect/stall phase.
module tb_ifetch_queue;
    localparam int DEPTH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    ifetch_queue_if bus();
    ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (.clk(clk), .reset(rst_n), .bus(bus));

    int checks = 0, failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Instruction memory: in-order, per-request latency in [lat_min, lat_max].
    typedef struct { logic [31:0] addr; int due; } mreq_t;
    mreq_t memq[$];
    int ready_mode = 0;   // 0 always ready, 1 random, 2 never
    int lat_min = 1, lat_max = 1;

    initial begin
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        forever begin
            @(negedge clk);
            if (!rst_n) memq.delete();
            else if (bus.imem_req_valid && bus.imem_req_ready)
                memq.push_back('{bus.imem_req_addr, cyc + int'($urandom_range(lat_max, lat_min))});
            @(posedge clk);
            #2;
            if (rst_n && memq.size() > 0 && memq[0].due <= cyc) begin
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_data  = mem_word(memq[0].addr);
                void'(memq.pop_front());
            end else begin
                bus.imem_rsp_valid = 1'b0;
                bus.imem_rsp_data  = $urandom;
            end
            bus.imem_req_ready = (ready_mode == 0) ? 1'b1 :
                                 (ready_mode == 2) ? 1'b0 : 1'($urandom_range(1, 0));
        end
    end

    // Reference: the delivered stream is pc, pc+4, ... restarting at each redirect target.
    typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;
    exp_t        expq[$];
    logic [31:0] model_pc = 32'h0;
    logic        halted = 1'b0;
    int          acc_cnt = 0, pop_cnt = 0;
    logic [31:0] last_pop_pc = 32'h0;
    logic        wrap_seen = 1'b0;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                expq.delete();
                model_pc = 32'h0;
                halted   = 1'b0;
                continue;
            end
            if (bus.instr_valid && bus.instr_ready) begin
                pop_cnt++;
                last_pop_pc = bus.instr_pc;
                if (bus.instr_pc == 32'hFFFF_FFFC) wrap_seen = 1'b1;
                if (expq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pop actual pc=%h required no instruction", bus.instr_pc);
                end else begin
                    e = expq.pop_front();
                    chk("instr_pc", bus.instr_pc, e.pc);
                    chk("instr", bus.instr, e.data);
                    chk("instr_pc_plus4", bus.instr_pc_plus4, e.pc + 32'd4);
                end
            end
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                acc_cnt++;
                chk("req_addr", bus.imem_req_addr, model_pc);
                chk("req_while_halted", {31'b0, halted}, 32'h0);
                expq.push_back('{model_pc, mem_word(model_pc)});
                model_pc = model_pc + 32'd4;
            end
            if (bus.redirect_valid) begin
                chk("req_in_redirect", {31'b0, bus.imem_req_valid}, 32'h0);
                expq.delete();
                model_pc = {bus.redirect_pc[31:2], 2'b00};
`ifdef IFETCH_MISALIGN_CHECK_EN
                halted = (bus.redirect_pc[1:0] != 2'b00);
`endif
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect(input logic [31:0] pc);
        step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = pc;
        step();
        bus.redirect_valid = 1'b0;
    endtask

    task automatic wait_pop(input string name);
        int p0 = pop_cnt;
        int n  = 0;
        while (pop_cnt == p0 && n < 60) begin
            step();
            n++;
        end
        if (pop_cnt == p0) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=no pop required=pop within 60 cycles", name);
        end
    endtask

    initial begin
        int a0, p0, n;
        logic [31:0] addr0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.instr_ready    = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_valid", {31'b0, bus.imem_req_valid}, 32'h0);
        chk("rst_instr_valid", {31'b0, bus.instr_valid}, 32'h0);
        chk("rst_instr", bus.instr, 32'h0);
        chk("rst_instr_pc", bus.instr_pc, 32'h0);
        chk("rst_instr_pc_plus4", bus.instr_pc_plus4, 32'h0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("boot_no_req", {31'b0, bus.imem_req_valid}, 32'h0);
        @(negedge clk);
        chk("first_req_valid", {31'b0, bus.imem_req_valid}, 32'h1);
        chk("first_req_addr", bus.imem_req_addr, 32'h0);

        // Steady state: one instruction per cycle.
        repeat (5) step();
        p0 = pop_cnt;
        repeat (20) step();
        chk("steady_throughput", pop_cnt - p0, 32'd20);

        // Decode stalled: exactly DEPTH fetches, then drain in order.
        step();
        bus.instr_ready = 1'b0;
        redirect(32'h0);
        a0 = acc_cnt;
        repeat (12) step();
        chk("stall_accepts", acc_cnt - a0, DEPTH);
        @(negedge clk);
        chk("full_no_req", {31'b0, bus.imem_req_valid}, 32'h0);
        step();
        bus.instr_ready = 1'b1;
        p0 = pop_cnt;
        repeat (4) step();
        chk("drain_count", pop_cnt - p0, 32'd4);
        chk("drain_last_pc", last_pop_pc, 32'hC);
        wait_pop("resume");
        chk("resume_pc", last_pop_pc, 32'h10);

        // Redirect with fetches in flight and one buffered.
        lat_min = 3;
        lat_max = 3;
        step();
        bus.instr_ready = 1'b0;
        redirect(32'h0);
        n = 0;
        while (!bus.instr_valid && n < 40) begin
            step();
            n++;
        end
        chk("buffered_before_redirect", {31'b0, bus.instr_valid}, 32'h1);
        redirect(32'h100);
        @(negedge clk);
        chk("valid_after_redirect", {31'b0, bus.instr_valid}, 32'h0);
        step();
        bus.instr_ready = 1'b1;
        wait_pop("redirect");
        chk("redirect_first_pc", last_pop_pc, 32'h100);

        // Memory not ready for 5 cycles: address held, single fetch.
        lat_min = 1;
        lat_max = 1;
        step();
        ready_mode = 2;
        repeat (4) step();
        a0    = acc_cnt;
        addr0 = bus.imem_req_addr;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", {31'b0, bus.imem_req_valid}, 32'h1);
            chk("hold_addr", bus.imem_req_addr, addr0);
        end
        step();
        ready_mode = 0;
        step();
        chk("hold_single_fetch", acc_cnt - a0, 32'd1);

        // PC wrap at 2^32.
        redirect(32'hFFFF_FFF8);
        repeat (12) step();
        chk("wrap_seen", {31'b0, wrap_seen}, 32'h1);

`ifdef IFETCH_MISALIGN_CHECK_EN
        redirect(32'h102);
        @(negedge clk);
        chk("misalign_set", {31'b0, bus.fetch_misalign}, 32'h1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("halt_no_req", {31'b0, bus.imem_req_valid}, 32'h0);
            chk("halt_no_valid", {31'b0, bus.instr_valid}, 32'h0);
        end
        redirect(32'h200);
        @(negedge clk);
        chk("misalign_clear", {31'b0, bus.fetch_misalign}, 32'h0);
        wait_pop("unhalt");
        chk("unhalt_first_pc", last_pop_pc, 32'h200);
`endif

        // Randomized: stalls, latencies, back-to-back redirects.
        lat_min    = 1;
        lat_max    = 3;
        ready_mode = 1;
        p0 = pop_cnt;
        for (int i = 0; i < 500; i++) begin
            step();
            bus.instr_ready    = ($urandom_range(3, 0) != 0);
            bus.redirect_valid = ($urandom_range(24, 0) == 0);
`ifdef IFETCH_MISALIGN_CHECK_EN
            bus.redirect_pc    = {$urandom_range(32'h3FFF, 0), 2'b00};
`else
            bus.redirect_pc    = $urandom;
`endif
        end
        step();
        bus.redirect_valid = 1'b0;
        bus.instr_ready    = 1'b1;
        ready_mode = 0;
        repeat (20) step();
        checks++;
        if (pop_cnt - p0 < 50) begin
            failures++;
            $display("FAIL random_progress actual=%0d pops required>=50", pop_cnt - p0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Instruction-fetch front end sitting directly upstream of the single-cycle processor datapath.
- Owns the fetch PC and issues in-order word requests to the instruction memory port.
- Buffers returned instructions in a small prefetch FIFO and presents them, tagged with their PC, to decode through a valid/ready handshake.
- On a branch/jump redirect it flushes buffered and in-flight fetches and restarts at the new PC.

Parameters:
- DEPTH, 4, prefetch slots; power of two, 2..16; also the cap on buffered plus outstanding fetches.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_req_addr  out  32  word address of the request.
- imem_rsp_valid  in  1  response data valid, in request order, at least 1 cycle after acceptance.
- imem_rsp_data  in  32  instruction word.
- redirect_valid  in  1  branch/jump taken; one-cycle pulse.
- redirect_pc  in  32  new fetch target.
- instr_valid  out  1  FIFO head valid.
- instr_ready  in  1  decode consumes head.
- instr  out  32  head instruction.
- instr_pc  out  32  PC of head instruction.
- instr_pc_plus4  out  32  instr_pc + 4, modulo 2^32.

Behaviour:
- Reset, asynchronous assert:
  - fetch_pc = RESET_PC; FIFO empty; outstanding = 0; kill = 0; state = BOOT.
  - imem_req_valid = 0, instr_valid = 0, and instr, instr_pc, instr_pc_plus4 = 0.
- States:
  - BOOT: one cycle, no requests; always goes to RUN.
  - RUN: normal fetch.
  - HALT: reached only with the optional feature enabled; left only on redirect or reset.
- Request issue in RUN:
  - imem_req_valid = 1 when (count + outstanding) < DEPTH and no redirect this cycle.
  - imem_req_addr = fetch_pc.
  - On valid & ready: fetch_pc += 4 (wraps at 2^32) and outstanding += 1.
  - Address and valid are held stable until accepted.
- Credit:
  - Uses registered count/outstanding.
  - A pop in cycle N frees its slot for a request in cycle N+1. No same-cycle bypass.
- Response:
  - imem_rsp_valid while kill > 0: discarded; kill -= 1, outstanding -= 1.
  - Otherwise: {data, pc} written to the FIFO tail; outstanding -= 1.
  - The PC tag comes from a parallel tag queue recorded at request acceptance.
  - imem_rsp_valid with outstanding = 0 is ignored.
- Output:
  - instr_valid = FIFO non-empty, registered head (zero-bubble: a response written to an empty FIFO appears the next cycle).
  - Pop on instr_valid & instr_ready.
  - Simultaneous push and pop at full or empty is legal; count is unchanged.
- Redirect (redirect_valid = 1):
  - In the same edge: FIFO flushed (count = 0); fetch_pc = redirect_pc; kill = outstanding, counting a request accepted this same cycle.
  - A response arriving in the redirect cycle is counted against kill.
  - A pop in the redirect cycle completes normally, then the flush applies.
  - instr_valid = 0 the cycle after a redirect.
  - A new request issues no earlier than the cycle after the redirect.
  - Back-to-back redirects: the last one wins; kill accumulates correctly.
- Full condition: count + outstanding = DEPTH means imem_req_valid = 0; nothing is dropped.
- Without the optional feature, imem_req_addr[1:0] is forced to 2'b00.

Optional Feature:
- Macro IFETCH_MISALIGN_CHECK_EN.
- Defined:
  - redirect_pc[1:0] != 0 moves the state to HALT and adds output fetch_misalign (1 bit), registered and sticky.
  - In HALT: no requests, FIFO flushed, in-flight responses killed, instr_valid = 0.
  - Only an aligned redirect or reset clears fetch_misalign and returns the state to RUN.
- Undefined:
  - No fetch_misalign port.
  - redirect_pc[1:0] is ignored (treated as 00); HALT is unreachable.

Test Plan:
- Reset release, memory always ready, 1-cycle latency, decode always ready -> first request addr 0x0 in cycle 2 after release; instr_pc sequence 0x0, 0x4, 0x8, and so on, one per cycle in steady state; instr_pc_plus4 = instr_pc + 4.
- decode stalled (instr_ready = 0), DEPTH = 4 -> exactly 4 requests accepted, then imem_req_valid = 0; release ready -> 4 instructions drain in order with pc 0x0 to 0xC, then fetch resumes at 0x10.
- Redirect to 0x100 with 2 requests outstanding and 1 buffered -> both late responses dropped; next instr_pc = 0x100; no instruction from 0x0 to 0xC ever appears after the redirect.
- imem_req_ready held low 5 cycles -> imem_req_addr is stable for all 5 cycles; exactly one fetch occurs at that address.
- fetch_pc = 0xFFFF_FFFC -> next request addr 0x0000_0000; instr_pc_plus4 of that instruction = 0x0.
- With IFETCH_MISALIGN_CHECK_EN, redirect to 0x102 -> fetch_misalign = 1, no requests, instr_valid = 0; later redirect to 0x200 -> fetch_misalign = 0 and first instr_pc = 0x200.
